// File: rtl/vid_rd_sched.sv
// ============================================================================
// Module   : vid_rd_sched
// Purpose  : Frame-buffer burst read scheduler (SDRAM clock domain), one burst
//            outstanding, throttled by video FIFO level and serial write path.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vid_rd_sched #(
  parameter int          ADDR_W      = 25,
  parameter int          BURST_LEN   = 8,
  parameter int          FRAME_WORDS = 240000,
  parameter int          BASE_ADDR   = 0,
  parameter logic [1:0]  HI_LEVEL    = 2'b11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_init_done,
  input  logic              i_vsync_async,
  input  logic [1:0]        i_fifo_level,
  input  logic              i_wr_req,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [8:0]        o_rd_len,
  input  logic              i_rd_ack,
  input  logic              i_rd_valid,
  input  logic              i_last_rd,
  output logic              o_frame_active,
  output logic              o_underrun,
  output logic              o_short_burst
);

  localparam logic [ADDR_W-1:0] c_BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_FRAME_END = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] c_STEP      = ADDR_W'(BURST_LEN);
  localparam logic [8:0]        c_BLEN      = 9'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_REQ  = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_ptr, w_ptr_nxt;
  logic [ADDR_W-1:0]  r_rd_addr;
  logic [8:0]         r_beats, w_beats_nxt;
  logic               r_rd_req, w_req_nxt;
  logic               r_frame_active, w_fa_nxt;
  logic               r_underrun, w_und_nxt;
  logic               r_short_burst, w_short_nxt;
  logic               r_restart, w_restart_nxt;
  logic               r_vs_meta, r_vs_sync, r_vs_prev;

  logic               w_fs_pulse;
  logic [8:0]         w_beats_inc;
  logic [ADDR_W-1:0]  w_ptr_inc;
  logic               w_burst_end;

  assign w_fs_pulse  = r_vs_sync & ~r_vs_prev;
  assign w_beats_inc = r_beats + 9'd1;
  assign w_ptr_inc   = r_ptr + c_STEP;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vs_meta <= 1'b0;
      r_vs_sync <= 1'b0;
      r_vs_prev <= 1'b0;
    end else begin
      r_vs_meta <= i_vsync_async;
      r_vs_sync <= r_vs_meta;
      r_vs_prev <= r_vs_sync;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_beats_nxt   = r_beats;
    w_req_nxt     = r_rd_req;
    w_fa_nxt      = r_frame_active;
    w_und_nxt     = r_underrun;
    w_short_nxt   = r_short_burst;
    w_restart_nxt = r_restart;
    w_burst_end   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_init_done && w_fs_pulse) begin
          w_ptr_nxt   = '0;
          w_fa_nxt    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (w_fs_pulse) begin
          w_und_nxt = 1'b1;
          w_ptr_nxt = '0;
        end else if (!i_init_done) begin
          w_fa_nxt    = 1'b0;
          w_state_nxt = S_IDLE;
        end else if ((i_fifo_level < HI_LEVEL) && !i_wr_req) begin
          w_req_nxt   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end

      // Once raised, the request stays up until acknowledged.
      S_REQ: begin
        if (w_fs_pulse) begin
          w_restart_nxt = 1'b1;
          w_und_nxt     = 1'b1;
        end
        if (i_rd_ack) begin
          w_req_nxt   = 1'b0;
          w_beats_nxt = '0;
          w_state_nxt = S_DATA;
        end
      end

      S_DATA: begin
        if (w_fs_pulse) begin
          w_restart_nxt = 1'b1;
          w_und_nxt     = 1'b1;
        end
        if (i_rd_valid) begin
          w_beats_nxt = w_beats_inc;
          if ((w_beats_inc == c_BLEN) || i_last_rd) w_burst_end = 1'b1;
          if (i_last_rd && (w_beats_inc < c_BLEN)) w_short_nxt = 1'b1;
        end
        if (w_burst_end) begin
          w_restart_nxt = 1'b0;
          if (!i_init_done) begin
            w_ptr_nxt   = '0;
            w_fa_nxt    = 1'b0;
            w_state_nxt = S_IDLE;
          end else if (r_restart || w_fs_pulse) begin
            w_ptr_nxt   = '0;
            w_state_nxt = S_WAIT;
          end else if (w_ptr_inc == c_FRAME_END) begin
            w_ptr_nxt   = w_ptr_inc;
            w_fa_nxt    = 1'b0;
            w_state_nxt = S_DONE;
          end else begin
            w_ptr_nxt   = w_ptr_inc;
            w_state_nxt = S_WAIT;
          end
        end
      end

      S_DONE: begin
        if (!i_init_done) begin
          w_state_nxt = S_IDLE;
        end else if (w_fs_pulse) begin
          w_ptr_nxt   = '0;
          w_fa_nxt    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end

      default: begin
        w_req_nxt   = 1'b0;
        w_fa_nxt    = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_ptr          <= '0;
      r_rd_addr      <= c_BASE;
      r_beats        <= '0;
      r_rd_req       <= 1'b0;
      r_frame_active <= 1'b0;
      r_underrun     <= 1'b0;
      r_short_burst  <= 1'b0;
      r_restart      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_ptr          <= w_ptr_nxt;
      r_rd_addr      <= c_BASE + w_ptr_nxt;
      r_beats        <= w_beats_nxt;
      r_rd_req       <= w_req_nxt;
      r_frame_active <= w_fa_nxt;
      r_underrun     <= w_und_nxt;
      r_short_burst  <= w_short_nxt;
      r_restart      <= w_restart_nxt;
    end
  end

  assign o_rd_req       = r_rd_req;
  assign o_rd_addr      = r_rd_addr;
  assign o_rd_len       = c_BLEN;
  assign o_frame_active = r_frame_active;
  assign o_underrun     = r_underrun;
  assign o_short_burst  = r_short_burst;

endmodule

`default_nettype wire

// File: tb/tb_vid_rd_sched.sv
// ============================================================================
// Module   : tb_vid_rd_sched
// Purpose  : Scoreboard bench for vid_rd_sched (reduced frame size).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vid_rd_sched;

  localparam int AW   = 25;
  localparam int BL   = 8;
  localparam int FW   = 800;
  localparam int BASE = 32'h1000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          init_done, vsync, wr_req, rd_ack, rd_valid, last_rd;
  logic [1:0]    fifo_level;
  logic          rd_req, frame_active, underrun, short_burst;
  logic [AW-1:0] rd_addr;
  logic [8:0]    rd_len;

  int n_vec = 0;
  int n_err = 0;
  int unsigned sb_q[$];
  int unsigned mptr;

  vid_rd_sched #(
    .ADDR_W(AW), .BURST_LEN(BL), .FRAME_WORDS(FW), .BASE_ADDR(BASE), .HI_LEVEL(2'b11)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .i_init_done(init_done), .i_vsync_async(vsync),
    .i_fifo_level(fifo_level), .i_wr_req(wr_req), .o_rd_req(rd_req), .o_rd_addr(rd_addr),
    .o_rd_len(rd_len), .i_rd_ack(rd_ack), .i_rd_valid(rd_valid), .i_last_rd(last_rd),
    .o_frame_active(frame_active), .o_underrun(underrun), .o_short_burst(short_burst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic no_req(input int n, input string tag);
    logic seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (rd_req) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  // Model: advance pointer after a burst, queue the next expected address.
  task automatic model_burst_done(input bit restart);
    mptr = restart ? 0 : mptr + BL;
    if (mptr != FW) sb_q.push_back(BASE + mptr);
  endtask

  task automatic do_burst(input int ack_dly, input int nbeats, input bit tog, input bit vs_mid);
    int n = 0;
    int unsigned exp;
    logic held = 1'b1;
    while (!rd_req && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!rd_req) begin
      chk("req_timeout", 32'd0, 32'd1);
      return;
    end
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      exp = 0;
    end else begin
      exp = sb_q.pop_front();
    end
    chk("rd_addr", 32'(rd_addr), exp);
    for (int k = 0; k < ack_dly; k++) begin
      if (tog) begin
        wr_req     = ~wr_req;
        fifo_level = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      if (!rd_req || (32'(rd_addr) != exp)) held = 1'b0;
    end
    wr_req     = 1'b0;
    fifo_level = 2'b00;
    chk("req_held", 32'(held), 32'd1);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    chk("req_drop", 32'(rd_req), 32'd0);
    if (vs_mid) begin
      vsync = 1'b1;
      repeat (4) @(negedge clk);
    end
    for (int b = 0; b < nbeats; b++) begin
      rd_valid = 1'b1;
      last_rd  = (b == nbeats - 1);
      @(negedge clk);
    end
    rd_valid = 1'b0;
    last_rd  = 1'b0;
    vsync    = 1'b0;
    model_burst_done(vs_mid);
  endtask

  initial begin
    reset_n = 1'b0; init_done = 1'b0; vsync = 1'b0; wr_req = 1'b0;
    rd_ack = 1'b0; rd_valid = 1'b0; last_rd = 1'b0; fifo_level = 2'b00;
    mptr = 0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(rd_req), 32'd0);
    chk("rst_addr", 32'(rd_addr), BASE);
    chk("rst_fa", 32'(frame_active), 32'd0);
    chk("rst_und", 32'(underrun), 32'd0);
    chk("rst_short", 32'(short_burst), 32'd0);
    chk("rd_len", 32'(rd_len), BL);
    reset_n = 1'b1;
    init_done = 1'b1;
    no_req(10, "idle_no_req");

    // Full frame, no disturbances.
    pulse_vsync();
    sb_q.push_back(BASE);
    mptr = 0;
    chk("fa_start", 32'(frame_active), 32'd1);
    for (int i = 0; i < FW / BL; i++) do_burst(2, BL, 1'b0, 1'b0);
    chk("fa_end", 32'(frame_active), 32'd0);
    chk("und_clean", 32'(underrun), 32'd0);
    no_req(20, "done_no_req");

    // FIFO high-level throttle.
    fifo_level = 2'b11;
    pulse_vsync();
    mptr = 0;
    sb_q.push_back(BASE);
    no_req(50, "fifo_hi_no_req");
    fifo_level = 2'b10;
    @(negedge clk);
    chk("fifo_drop_req", 32'(rd_req), 32'd1);
    chk("fifo_drop_addr", 32'(rd_addr), BASE);
    do_burst(2, BL, 1'b0, 1'b0);

    // Write-path priority, then long ack with toggling wr_req/fifo_level.
    wr_req = 1'b1;
    no_req(20, "wr_req_no_req");
    wr_req = 1'b0;
    do_burst(20, BL, 1'b1, 1'b0);

    // Frame restart mid-burst at ptr=400.
    while (mptr < 400) do_burst(1, BL, 1'b0, 1'b0);
    chk("und_before", 32'(underrun), 32'd0);
    do_burst(2, BL, 1'b0, 1'b1);
    chk("und_set", 32'(underrun), 32'd1);
    do_burst(2, BL, 1'b0, 1'b0);
    chk("und_sticky", 32'(underrun), 32'd1);
    chk("fa_restart", 32'(frame_active), 32'd1);

    // Short burst: last_rd on beat 5.
    chk("short_before", 32'(short_burst), 32'd0);
    do_burst(2, 5, 1'b0, 1'b0);
    chk("short_set", 32'(short_burst), 32'd1);
    do_burst(2, BL, 1'b0, 1'b0);
    chk("short_sticky", 32'(short_burst), 32'd1);

    // Asynchronous reset while a request is pending.
    begin
      int n = 0;
      while (!rd_req && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("pre_rst_req", 32'(rd_req), 32'd1);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req", 32'(rd_req), 32'd0);
    chk("arst_addr", 32'(rd_addr), BASE);
    chk("arst_fa", 32'(frame_active), 32'd0);
    chk("arst_und", 32'(underrun), 32'd0);
    chk("arst_short", 32'(short_burst), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    sb_q.delete();
    no_req(30, "post_rst_no_req");
    pulse_vsync();
    mptr = 0;
    sb_q.push_back(BASE);
    do_burst(2, BL, 1'b0, 1'b0);
    do_burst(2, BL, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vid_rd_sched.md
Name: vid_rd_sched

Overview:
- Read-request scheduler for the video frame buffer, in the SDRAM clock domain.
- Issues fixed-length burst read requests to the SDRAM controller application port, one burst outstanding at a time.
- Walks a linear frame address range, restarting at each frame start.
- Throttles on the video FIFO fill level. Sits directly upstream of the video FIFO / pixel output path, and beside the serial write path that shares the controller port.

Parameters:
ADDR_W, 25, SDRAM application address width (32-bit words)
BURST_LEN, 8, words per read burst; power of two, 1..256
FRAME_WORDS, 240000, words per frame (800x600 at 16 bpp, 2 px/word); multiple of BURST_LEN
BASE_ADDR, 0, word address of the first frame word
HI_LEVEL, 2'b11, fifo_level value at or above which no new burst is issued

Ports:
clk  in  1  SDRAM/controller clock
reset_n  in  1  asynchronous active-low reset
init_done  in  1  SDRAM initialisation complete
vsync_async  in  1  vertical sync from the video clock domain, active high; its rising edge marks a frame start
fifo_level  in  2  quantised video FIFO write-side fill level
wr_req  in  1  serial write path request pending
rd_req  out  1  burst read request
rd_addr  out  ADDR_W  burst start address
rd_len  out  9  burst length, constant BURST_LEN
rd_ack  in  1  controller accepted the request
rd_valid  in  1  read data beat valid
last_rd  in  1  last beat of the burst
frame_active  out  1  high while the current frame is being fetched
underrun  out  1  sticky; set when a frame start arrives before the previous frame completed
short_burst  out  1  sticky; set when last_rd arrives before BURST_LEN beats

Behaviour:
- Reset values: rd_req=0, rd_addr=BASE_ADDR, frame_active=0, underrun=0, short_burst=0, word pointer=0, FSM=IDLE.
- rd_len is driven as BURST_LEN at all times.
- vsync_async passes through a 2-flop synchroniser plus an edge-detect flop. fs_pulse is one clk wide on the synchronised rising edge, so latency is 3 clk.
- rd_addr = BASE_ADDR + ptr, registered. ptr is ADDR_W bits.
- FSM states:
  - IDLE: wait for init_done=1 and fs_pulse. Then ptr=0, frame_active=1, go to WAIT.
  - WAIT: when fifo_level < HI_LEVEL and wr_req=0, assert rd_req on the next clk and go to REQ. Otherwise hold.
  - REQ: hold rd_req=1 and rd_addr stable until rd_ack. On the ack cycle: drop rd_req on the next clk, clear the beat counter, go to DATA. A request is never withdrawn once asserted, whatever wr_req, fifo_level or fs_pulse do.
  - DATA: count rd_valid beats. The burst ends on the first of: beat count reaching BURST_LEN, or last_rd=1 with rd_valid=1. If it ends on last_rd with count < BURST_LEN, set short_burst. At burst end, ptr += BURST_LEN. If the new ptr equals FRAME_WORDS, clear frame_active and go to DONE; else go to WAIT.
  - DONE: wait for fs_pulse. Then ptr=0, frame_active=1, go to WAIT.
- Frame start during WAIT: set underrun, ptr=0, stay in WAIT with frame_active=1.
- Frame start during REQ or DATA: latch a restart flag and set underrun. The current burst completes normally. At burst end, ptr=0 and go to WAIT regardless of FRAME_WORDS. The flag then clears.
- Frame start in IDLE or DONE is the normal start; underrun is not set.
- init_done falling while not in IDLE: finish any outstanding REQ/DATA, then return to IDLE with frame_active=0. Sticky flags are kept.
- A fifo_level change during REQ/DATA has no effect. It is only sampled in WAIT.
- Back-to-back bursts: minimum 1 idle clk between rd_req deassert and the next rd_req assert (DATA->WAIT->REQ).
- Sticky flags clear only on reset.
- reset_n asserted mid-burst: all outputs return to reset values immediately. The controller-side transaction is abandoned; this is handled by the shared reset.

Test Plan:
- Reset, init_done=1, one vsync pulse, fifo_level=0, rd_ack 2 clk after each rd_req, 8 rd_valid beats each -> rd_addr steps 0,8,16,...; after 30000 bursts frame_active falls, FSM idles, underrun=0.
- fifo_level=2'b11 in WAIT for 50 clk -> rd_req stays 0. Drop to 2'b10 -> rd_req rises 1 clk later with the unchanged address.
- wr_req=1 in WAIT -> no rd_req. rd_ack delayed 20 clk while wr_req toggles -> rd_req held high and rd_addr stable throughout.
- vsync rising mid-DATA at ptr=400 -> burst completes, next rd_addr=BASE_ADDR, underrun=1 and stays set.
- last_rd with rd_valid on beat 5 of 8 -> short_burst=1, ptr advances by 8, next rd_addr = previous + 8.
- reset_n pulsed low during REQ -> rd_req=0 and rd_addr=BASE_ADDR asynchronously; no request until init_done and the next vsync edge.
